// File: rtl/tank_move_sequencer.sv
// tank_move_sequencer: round-robin move sequencer that reads both tanks and the
// target wall cell from storage, then issues exactly one move or turn write.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   p1_req, p1_dir     player 1 request level and direction code
//   p2_req, p2_dir     player 2 request level and direction code
//   p1_ack, p2_ack     one-cycle completion pulses
//   moved              with ack: 1 = position changed
//   busy               high whenever a request is being processed
//   mode, address,     storage command bus, owned by this block
//   data, wren,
//   load_out
//   q                  storage read data, sampled READ_LAT cycles after issue
module tank_move_sequencer #(
   parameter int unsigned READ_LAT = 2,
   parameter logic [3:0]  GRID_MAX = 4'hF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       p1_req,
   input  logic [7:0] p1_dir,
   input  logic       p2_req,
   input  logic [7:0] p2_dir,
   output logic       p1_ack,
   output logic       p2_ack,
   output logic       moved,
   output logic       busy,
   output logic [3:0] mode,
   output logic [7:0] address,
   output logic [7:0] data,
   output logic       wren,
   output logic       load_out,
   input  logic [7:0] q
);
   typedef enum logic [2:0] {IDLE, RD_SELF, RD_OTHER, CALC, RD_WALL, DECIDE, WRITE, ACK} state_t;
   localparam logic [2:0] LAT = 3'(READ_LAT);
   state_t     state;
   logic       gnt;
   logic       last_grant;
   logic [7:0] dir_l, self_pos, other_pos, target, wall_q;
   logic [2:0] cnt;
   logic       at_edge, blocked;
   logic       pick, dir_ok, nxt_edge, blk_now;
   logic [7:0] pick_dir, nxt;
   logic [3:0] own_mode, oth_mode, dir_mode;
   always_comb begin
      // gnt/pick/last_grant: 0 = player 1, 1 = player 2
      pick     = (p1_req && p2_req) ? ~last_grant : p2_req;
      pick_dir = pick ? p2_dir : p1_dir;
      dir_ok   = pick_dir inside {8'h00, 8'h01, 8'h03, 8'h07};
      own_mode = gnt ? 4'b0101 : 4'b0001;
      oth_mode = gnt ? 4'b0001 : 4'b0101;
      dir_mode = gnt ? 4'b0110 : 4'b0010;
      nxt_edge = (dir_l == 8'h00 && self_pos[7:4] == 4'h0) ||
                 (dir_l == 8'h01 && self_pos[7:4] == GRID_MAX) ||
                 (dir_l == 8'h03 && self_pos[3:0] == 4'h0) ||
                 (dir_l == 8'h07 && self_pos[3:0] == GRID_MAX);
      nxt      = dir_l == 8'h00 ? self_pos - 8'h10 :
                 dir_l == 8'h01 ? self_pos + 8'h10 :
                 dir_l == 8'h03 ? self_pos - 8'h01 : self_pos + 8'h01;
      // wall_q is cleared on the edge path, so only at_edge matters there
      blk_now  = at_edge | (|wall_q) | (target == other_pos);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         dir_l      <= 8'h00;
         self_pos   <= 8'h00;
         other_pos  <= 8'h00;
         target     <= 8'h00;
         wall_q     <= 8'h00;
         cnt        <= 3'd0;
         at_edge    <= 1'b0;
         blocked    <= 1'b0;
         p1_ack     <= 1'b0;
         p2_ack     <= 1'b0;
         moved      <= 1'b0;
         busy       <= 1'b0;
         mode       <= 4'b0000;
         address    <= 8'h00;
         data       <= 8'h00;
         wren       <= 1'b0;
         load_out   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (p1_req || p2_req) begin
               gnt   <= pick;
               dir_l <= pick_dir;
               busy  <= 1'b1;
               if (dir_ok) begin
                  state    <= RD_SELF;
                  mode     <= pick ? 4'b0101 : 4'b0001;
                  load_out <= 1'b1;
                  cnt      <= LAT;
               end else begin
                  // bad direction: complete immediately without touching storage
                  state  <= ACK;
                  p1_ack <= ~pick;
                  p2_ack <= pick;
                  moved  <= 1'b0;
               end
            end
            RD_SELF: begin
               load_out <= 1'b0;
               if (cnt == 3'd0) begin
                  self_pos <= q;
                  state    <= RD_OTHER;
                  mode     <= oth_mode;
                  load_out <= 1'b1;
                  cnt      <= LAT;
               end else cnt <= cnt - 3'd1;
            end
            RD_OTHER: begin
               load_out <= 1'b0;
               if (cnt == 3'd0) begin
                  other_pos <= q;
                  state     <= CALC;
                  mode      <= 4'b0000;
               end else cnt <= cnt - 3'd1;
            end
            CALC: begin
               at_edge <= nxt_edge;
               target  <= nxt;
               wall_q  <= 8'h00;
               if (nxt_edge) state <= DECIDE;
               else begin
                  state    <= RD_WALL;
                  address  <= nxt;
                  load_out <= 1'b1;
                  cnt      <= LAT;
               end
            end
            RD_WALL: begin
               load_out <= 1'b0;
               if (cnt == 3'd0) begin
                  wall_q <= q;
                  state  <= DECIDE;
               end else cnt <= cnt - 3'd1;
            end
            DECIDE: begin
               blocked <= blk_now;
               state   <= WRITE;
               wren    <= 1'b1;
               data    <= dir_l;
               mode    <= blk_now ? dir_mode : own_mode;
            end
            WRITE: begin
               wren    <= 1'b0;
               state   <= ACK;
               p1_ack  <= ~gnt;
               p2_ack  <= gnt;
               moved   <= ~blocked;
               mode    <= 4'b0000;
               address <= 8'h00;
               data    <= 8'h00;
            end
            ACK: begin
               p1_ack     <= 1'b0;
               p2_ack     <= 1'b0;
               moved      <= 1'b0;
               busy       <= 1'b0;
               last_grant <= gnt;
               mode       <= 4'b0000;
               address    <= 8'h00;
               data       <= 8'h00;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tank_move_sequencer.sv
// tb_tank_move_sequencer: three latency lanes, each with a storage model and a
// transaction-level reference of the arbitration and move rules.
module tb_tank_move_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0, failures = 0, ndone = 0;

   task automatic chk(input int lane, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL lane%0d %s actual=%0h expected=%0h", lane, nm, act, exp);
      end
   endtask

   function automatic logic [7:0] rdir(input bit any);
      logic [7:0] c [4] = '{8'h00, 8'h01, 8'h03, 8'h07};
      return (any && $urandom_range(0, 7) == 0) ? 8'($urandom) : c[$urandom_range(0, 3)];
   endfunction

   for (genvar k = 0; k < 3; k++) begin : lane
      localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 4;
      logic rn, r1, r2, a1, a2, mv, bz, we, lo;
      logic [7:0] d1, d2, qv, ad, dt;
      logic [3:0] md;
      tank_move_sequencer #(.READ_LAT(L)) dut (
         .clk(clk), .resetn(rn), .p1_req(r1), .p1_dir(d1), .p2_req(r2), .p2_dir(d2),
         .p1_ack(a1), .p2_ack(a2), .moved(mv), .busy(bz), .mode(md), .address(ad),
         .data(dt), .wren(we), .load_out(lo), .q(qv));
      logic [7:0] wall [256];
      logic [7:0] tk [2];
      logic [7:0] x_t1 [5] = '{8'h00, 8'h00, 8'h00, 8'h44, 8'h00};
      logic [7:0] x_t2 [5] = '{8'hFF, 8'hFF, 8'h45, 8'h45, 8'hFF};
      logic [7:0] x_wa [5] = '{8'h10, 8'h10, 8'h44, 8'h44, 8'h10};
      logic [7:0] x_wv [5] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
      int         x_pl [5] = '{1, 1, 2, 2, 1};
      logic [7:0] x_dr [5] = '{8'h01, 8'h00, 8'h03, 8'h03, 8'h05};
      logic       x_mv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] x_wm [5] = '{4'h1, 4'h2, 4'h6, 4'h6, 4'hF};
      int lg, g, prevg, ph, dix, ntx, cyc, rdy, lat, wait_n, rd_n, wr_n, erd_n, elat, dr, dc, nr, nc;
      logic [7:0] dir, tgt, rval, wr_md, wr_dt;
      logic [3:0] rd_md [4];
      logic [7:0] rd_ad [4];
      logic valid, edg, blk, in_tx, armed, fired, rel, stop, hit;

      initial begin : run
         rn = 1'b1; r1 = 0; r2 = 0; d1 = 0; d2 = 0; qv = 0;
         lg = 2; prevg = 0; ph = 0; dix = 0; ntx = 0; cyc = 0; rdy = -1; lat = 0; wait_n = 0;
         rd_n = 0; wr_n = 0; in_tx = 0; armed = 0; fired = 0; rel = 0; stop = 0;
         for (int i = 0; i < 256; i++) wall[i] = 8'h00;
         #1 rn = 1'b0;
         repeat (3) @(negedge clk);
         chk(k, "reset_outs", {md, ad, dt, we, lo, a1, a2, mv, bz}, 0);
         rn = 1'b1;
         while (!stop && ntx < 40) begin
            if (ph == 0 && dix < 5 && !r1 && !r2 && !in_tx) begin
               tk[0] = x_t1[dix]; tk[1] = x_t2[dix]; wall[x_wa[dix]] = x_wv[dix];
               if (x_pl[dix] == 1) begin r1 = 1; d1 = x_dr[dix]; end
               else begin r2 = 1; d2 = x_dr[dix]; end
            end
            @(negedge clk);
            cyc++;
            hit = 0;
            if (rel) begin
               chk(k, "reset_held_outs", {md, ad, dt, we, lo, a1, a2, mv, bz}, 0);
               rn = 1'b1; rel = 0;
            end
            if (bz && !in_tx) begin
               in_tx = 1; lat = 0; rd_n = 0; wr_n = 0;
               g = (r1 && r2) ? (lg == 1 ? 2 : 1) : (r1 ? 1 : 2);
               dir = (g == 1) ? d1 : d2;
               dr = 0; dc = 0;
               case (dir)
                  8'h00: dr = -1;
                  8'h01: dr = 1;
                  8'h03: dc = -1;
                  8'h07: dc = 1;
                  default: ;
               endcase
               valid = (dr != 0 || dc != 0);
               nr = int'(tk[g-1][7:4]) + dr;
               nc = int'(tk[g-1][3:0]) + dc;
               edg = nr < 0 || nr > 15 || nc < 0 || nc > 15;
               tgt = {4'(nr), 4'(nc)};
               blk = !valid || edg || wall[tgt] != 8'h00 || tgt == tk[2-g];
               erd_n = !valid ? 0 : edg ? 2 : 3;
               elat = !valid ? 0 : erd_n * (L + 1) + 3;
            end
            chk(k, "we_lo_excl", we && lo, 0);
            chk(k, "one_ack", a1 && a2, 0);
            if (in_tx) chk(k, "busy_held", bz, 1);
            else chk(k, "idle_quiet", {we, lo, a1, a2}, 0);
            if (in_tx && !(a1 || a2)) lat++;
            if (lo && rd_n < 4) begin rd_md[rd_n] = md; rd_ad[rd_n] = ad; rd_n++; end
            if (we) begin wr_n++; wr_md = md; wr_dt = dt; end
            qv = (cyc == rdy) ? rval : 8'($urandom);
            if (lo) begin
               rdy = cyc + L;
               rval = md == 4'h1 ? tk[0] : md == 4'h5 ? tk[1] : md == 4'h0 ? wall[ad] : 8'h00;
            end
            if (armed && ntx >= 16 && in_tx && lo && md == 4'h0) begin
               rn = 1'b0;
               #1;
               chk(k, "async_reset_outs", {md, ad, dt, we, lo, a1, a2, mv, bz}, 0);
               chk(k, "abort_no_write", wr_n, 0);
               in_tx = 0; lg = 2; rdy = -1; armed = 0; fired = 1; rel = 1; hit = 1;
            end
            if (!hit && in_tx && (a1 || a2)) begin
               chk(k, "ack_p1", a1, g == 1);
               chk(k, "ack_p2", a2, g == 2);
               chk(k, "moved", mv, !blk);
               chk(k, "ack_mode", md, 0);
               chk(k, "reads", rd_n, erd_n);
               for (int i = 0; i < 3; i++)
                  if (i < rd_n && i < erd_n)
                     chk(k, "rd_mode", rd_md[i], i == 0 ? (g == 1 ? 1 : 5) : i == 1 ? (g == 1 ? 5 : 1) : 0);
               if (erd_n == 3 && rd_n == 3) chk(k, "wall_addr", rd_ad[2], tgt);
               chk(k, "writes", wr_n, valid);
               if (valid && wr_n == 1) begin
                  chk(k, "wr_mode", wr_md, blk ? (g == 1 ? 2 : 6) : (g == 1 ? 1 : 5));
                  chk(k, "wr_data", wr_dt, dir);
               end
               chk(k, "latency", lat, elat);
               if (ph == 0) begin
                  chk(k, "lit_moved", mv, x_mv[dix]);
                  if (x_wm[dix] != 4'hF) chk(k, "lit_wmode", wr_md, x_wm[dix]);
                  else begin
                     chk(k, "lit_no_access", wr_n + rd_n, 0);
                     chk(k, "lit_fast_ack", lat, 0);
                  end
                  if (dix == 0) chk(k, "lit_wall_addr", rd_ad[2], 8'h10);
               end
               if (ph == 1 && prevg != 0) chk(k, "alternate", g, 3 - prevg);
               prevg = g;
               if (valid && !blk) tk[g-1] = tgt;
               lg = g; in_tx = 0; ntx++;
               if (ph != 1) begin
                  if (g == 1) r1 = 0; else r2 = 0;
               end
               if (ph == 0) begin
                  dix++;
                  if (dix == 5) ph = 1;
               end else if (ph == 1 && ntx == 11) begin
                  ph = 2; armed = 1;
                  for (int i = 0; i < 256; i++) wall[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                  tk[0] = 8'($urandom); tk[1] = 8'($urandom);
               end
            end
            if (in_tx && lat > 20 * (L + 1) + 20) begin
               failures++; stop = 1;
               $display("FAIL lane%0d ack_timeout actual=%0d expected<=%0d", k, lat, 20 * (L + 1) + 20);
            end
            wait_n = (!in_tx && (r1 || r2)) ? wait_n + 1 : 0;
            if (wait_n > 8) begin
               failures++; stop = 1;
               $display("FAIL lane%0d grant_timeout actual=%0d expected<=8", k, wait_n);
            end
            if (in_tx) begin
               if (g == 1) d1 = rdir(ph == 2); else d2 = rdir(ph == 2);
            end
            if (ph == 1) begin
               if (!r1) begin r1 = 1; d1 = rdir(0); end
               if (!r2) begin r2 = 1; d2 = rdir(0); end
            end else if (ph == 2) begin
               if (!r1 && $urandom_range(0, 2) == 0) begin r1 = 1; d1 = rdir(1); end
               if (!r2 && $urandom_range(0, 2) == 0) begin r2 = 1; d2 = rdir(1); end
            end
         end
         chk(k, "reset_fired", fired, 1);
         ndone++;
      end
   end

   initial begin
      for (int t = 0; t < 60000 && ndone < 3; t++) @(posedge clk);
      if (ndone < 3) begin
         failures++;
         $display("FAIL global_timeout actual=%0d expected=3", ndone);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
